// File: rtl/opb_s2p_pkg.sv
// rtl/opb_s2p_pkg.sv - shared offsets, bit indices and FSM states for the simulink2ppc OPB register
// Purpose: constants shared by the OPB slave FSM and the register top.
// Ports: none (package).
package opb_s2p_pkg;

    // Word offsets (OPB_ABus[28:29])
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // Bit indices in OPB numbering (bit 0 = MSB)
    localparam int STATUS_VALID_BIT   = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int CTRL_CLEAR_BIT     = 30;
    localparam int CTRL_CAP_EN_BIT    = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - address decode and single-beat IDLE/ACK handshake
// Purpose: decodes the OPB address window and produces a one-cycle xferAck one
//   cycle after a hit seen in IDLE.
// Ports: clk/rst (async active-high), abus/select/rnw from OPB;
//   ack (registered xferAck), rd_strobe/wr_strobe (hit cycle, combinational),
//   offset (word offset within the window).
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01000400,
    parameter logic [31:0] C_HIGHADDR = 32'h010004FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:31] abus,
    input  logic        select,
    input  logic        rnw,
    output logic        ack,
    output logic        rd_strobe,
    output logic        wr_strobe,
    output logic [1:0]  offset
);

    ack_state_e state_q, state_d;
    logic       hit;
    logic       start;

    assign hit    = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign offset = abus[28:29];

    // Only IDLE accepts a request, so a select held through the ack cycle
    // cannot start a second transfer.
    assign start     = (state_q == ST_IDLE) && hit;
    assign rd_strobe = start && rnw;
    assign wr_strobe = start && !rnw;
    assign ack       = (state_q == ST_ACK);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// rtl/opb_register_simulink2ppc.sv - OPB slave exposing a fabric-produced word to PPC software
// Purpose: latches user_data_in on user_valid, tracks valid/overrun/update count,
//   and serves DATA/STATUS/CTRL over OPB.
// Ports: OPB_Clk/OPB_Rst (async active-high); OPB slave outputs Sl_*; OPB master
//   inputs OPB_*; fabric side user_data_in/user_valid in, user_read_pulse out.
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010004FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_read_pulse
);

    logic        ack, rd_strobe, wr_strobe;
    logic [1:0]  offset;

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic [15:0] count_q, count_d;
    logic        cap_en_q, cap_en_d;
    logic [0:C_OPB_DWIDTH-1] sl_dbus_q, sl_dbus_d;
    logic        read_pulse_q, read_pulse_d;

    logic [0:C_OPB_DWIDTH-1] rd_word;
    logic        capture, ctrl_wr, clear;
    logic        unused_inputs;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk       (OPB_Clk),
        .rst       (OPB_Rst),
        .abus      (OPB_ABus),
        .select    (OPB_select),
        .rnw       (OPB_RNW),
        .ack       (ack),
        .rd_strobe (rd_strobe),
        .wr_strobe (wr_strobe),
        .offset    (offset)
    );

    assign Sl_xferAck      = ack;
    assign Sl_DBus         = sl_dbus_q;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_read_pulse = read_pulse_q;

    // Burst hint and the non-CTRL byte lanes carry nothing this block needs.
    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};

    assign capture = user_valid && cap_en_q;
    assign ctrl_wr = wr_strobe && (offset == OFF_CTRL) && OPB_BE[3];
    assign clear   = ctrl_wr && OPB_DBus[CTRL_CLEAR_BIT];

    // Read data is taken from the register state in the hit cycle, so a capture
    // landing on the same edge is not visible until the next read.
    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_DATA:   rd_word = data_q;
            OFF_STATUS: begin
                rd_word[STATUS_VALID_BIT]   = valid_q;
                rd_word[STATUS_OVERRUN_BIT] = overrun_q;
                rd_word[16:31]              = count_q;
            end
            OFF_CTRL:   rd_word[CTRL_CAP_EN_BIT] = cap_en_q;
            default:    rd_word = '0;
        endcase
        sl_dbus_d    = rd_strobe ? rd_word : '0;
        read_pulse_d = rd_strobe && (offset == OFF_DATA);
    end

    // read_pulse_q marks the DATA-read ack cycle, which is when valid is consumed.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        cap_en_d  = cap_en_q;
        if (clear) begin
            overrun_d = 1'b0;
            count_d   = '0;
        end
        if (capture) begin
            data_d  = user_data_in;
            valid_d = 1'b1;
            count_d = count_d + 16'd1;
            // A word consumed by this cycle's DATA read is not overwritten unread.
            if (valid_q && !read_pulse_q && !clear) overrun_d = 1'b1;
        end else if (read_pulse_q) begin
            valid_d = 1'b0;
        end
        if (ctrl_wr) cap_en_d = OPB_DBus[CTRL_CAP_EN_BIT];
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= '0;
            cap_en_q     <= 1'b1;
            sl_dbus_q    <= '0;
            read_pulse_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
            cap_en_q     <= cap_en_d;
            sl_dbus_q    <= sl_dbus_d;
            read_pulse_q <= read_pulse_d;
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// tb/tb_opb_register_simulink2ppc.sv - self-checking bench for opb_register_simulink2ppc
module tb_opb_register_simulink2ppc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sl_dbus;
    logic        sl_erracK, sl_retry, sl_toutsup, sl_xferack;
    logic [31:0] opb_abus = '0;
    logic [0:3]  opb_be = '0;
    logic [31:0] opb_dbus = '0;
    logic        opb_rnw = 1'b0;
    logic        opb_select = 1'b0;
    logic        opb_seqaddr = 1'b0;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;
    logic        user_read_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    opb_register_simulink2ppc dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .Sl_DBus         (sl_dbus),
        .Sl_errAck       (sl_erracK),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_toutsup),
        .Sl_xferAck      (sl_xferack),
        .OPB_ABus        (opb_abus),
        .OPB_BE          (opb_be),
        .OPB_DBus        (opb_dbus),
        .OPB_RNW         (opb_rnw),
        .OPB_select      (opb_select),
        .OPB_seqAddr     (opb_seqaddr),
        .user_data_in    (user_data_in),
        .user_valid      (user_valid),
        .user_read_pulse (user_read_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model of the software-visible state
    logic [31:0] m_data;
    bit          m_valid, m_ovr, m_cap;
    int          m_cnt;

    task automatic model_reset();
        m_data = 0; m_valid = 0; m_ovr = 0; m_cap = 1; m_cnt = 0;
    endtask

    task automatic model_cycle(input bit uv, input logic [31:0] ud, input bit data_read_ack,
                               input bit clr, input bit cap_wr, input bit cap_val);
        bit cap;
        cap = uv && m_cap;
        if (clr) begin m_ovr = 0; m_cnt = 0; end
        if (cap) begin
            if (m_valid && !data_read_ack && !clr) m_ovr = 1;
            m_data  = ud;
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (data_read_ack) begin
            m_valid = 0;
        end
        if (cap_wr) m_cap = cap_val;
    endtask

    function automatic logic [31:0] model_reg(input int off);
        case (off)
            0: return m_data;
            1: return (32'(m_valid) << 31) | (32'(m_ovr) << 30) | 32'(m_cnt);
            2: return 32'(m_cap);
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1; opb_select = 0; user_valid = 0; opb_abus = 0; opb_rnw = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Starts and ends at a negedge. Cycle N = request, cycle N+1 = ack, N+2 = idle.
    task automatic xfer(input bit sel, input logic [31:0] addr, input bit rnw, input logic [0:3] be,
                        input logic [31:0] wd, input bit hold, input bit uv0, input logic [31:0] ud0,
                        input bit uv1, input logic [31:0] ud1,
                        output bit ack1, output logic [31:0] d1, output bit pulse1,
                        output bit ack2, output logic [31:0] d2);
        opb_select = sel; opb_abus = addr; opb_rnw = rnw; opb_be = be; opb_dbus = wd;
        user_valid = uv0; user_data_in = ud0;
        @(posedge clk); @(negedge clk);
        ack1 = sl_xferack; d1 = sl_dbus; pulse1 = user_read_pulse;
        if (!hold) opb_select = 0;
        user_valid = uv1; user_data_in = ud1;
        @(posedge clk); @(negedge clk);
        opb_select = 0; user_valid = 0;
        ack2 = sl_xferack; d2 = sl_dbus;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bit a1, p1, a2; logic [31:0] d1, d2;
        xfer(1, addr, 1, 4'hF, 0, 0, 0, 0, 0, 0, a1, d1, p1, a2, d2);
        check({name, " ack"}, 32'(a1), 1);
        check(name, d1, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [0:3] be, input logic [31:0] wd);
        bit a1, p1, a2; logic [31:0] d1, d2;
        xfer(1, addr, 0, be, wd, 0, 0, 0, 0, 0, a1, d1, p1, a2, d2);
        check("wr ack", 32'(a1), 1);
    endtask

    task automatic capture(input logic [31:0] w);
        user_valid = 1; user_data_in = w;
        @(posedge clk); @(negedge clk);
        user_valid = 0;
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] addr;
        bit          rnw;
        logic [0:3]  be;
        logic [31:0] wd;
        bit          exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    initial begin
        bit a1, p1, a2;
        logic [31:0] d1, d2, tmp;

        vecs[0]  = '{1, 32'h01000404, 1, 4'hF, 32'h0,        1, 32'h0};
        vecs[1]  = '{1, 32'h01000408, 1, 4'hF, 32'h0,        1, 32'h1};
        vecs[2]  = '{1, 32'h01000400, 1, 4'hF, 32'h0,        1, 32'h0};
        vecs[3]  = '{1, 32'h0100040C, 1, 4'hF, 32'h0,        1, 32'h0};
        vecs[4]  = '{1, 32'h010004FF, 1, 4'hF, 32'h0,        1, 32'h0};
        vecs[5]  = '{1, 32'h01000500, 1, 4'hF, 32'h0,        0, 32'h0};
        vecs[6]  = '{1, 32'h010003FC, 1, 4'hF, 32'h0,        0, 32'h0};
        vecs[7]  = '{0, 32'h01000408, 1, 4'hF, 32'h0,        0, 32'h0};
        vecs[8]  = '{1, 32'h0100040C, 0, 4'hF, 32'hFFFFFFFF, 1, 32'h0};
        vecs[9]  = '{1, 32'h01000408, 0, 4'b1110, 32'h0,     1, 32'h0};
        vecs[10] = '{1, 32'h01000408, 1, 4'hF, 32'h0,        1, 32'h1};
        vecs[11] = '{1, 32'h01000404, 0, 4'hF, 32'hFFFFFFFF, 1, 32'h0};
        vecs[12] = '{1, 32'h01000404, 1, 4'hF, 32'h0,        1, 32'h0};
        vecs[13] = '{1, 32'h01000400, 0, 4'hF, 32'h12345678, 1, 32'h0};
        vecs[14] = '{1, 32'h01000400, 1, 4'hF, 32'h0,        1, 32'h0};

        // Reset state
        @(negedge clk);
        do_reset();
        check("reset xferAck", 32'(sl_xferack), 0);
        check("reset DBus", sl_dbus, 0);
        check("reset read_pulse", 32'(user_read_pulse), 0);
        check("tied outputs", {29'b0, sl_erracK, sl_retry, sl_toutsup}, 0);

        // Decode/map vectors from reset state
        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].sel, vecs[i].addr, vecs[i].rnw, vecs[i].be, vecs[i].wd, 0, 0, 0, 0, 0,
                 a1, d1, p1, a2, d2);
            tmp = vecs[i].addr;
            check($sformatf("vec%0d ack", i), 32'(a1), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d data", i), d1, vecs[i].exp_rd);
            check($sformatf("vec%0d pulse", i), 32'(p1),
                  32'(vecs[i].exp_ack && vecs[i].rnw && tmp[3:2] == 2'd0));
            check($sformatf("vec%0d ack drop", i), 32'(a2), 0);
            check($sformatf("vec%0d dbus drop", i), d2, 0);
        end

        // Capture then DATA read, select held through the ack cycle
        capture(32'hDEADBEEF);
        xfer(1, 32'h01000400, 1, 4'hF, 0, 1, 0, 0, 0, 0, a1, d1, p1, a2, d2);
        check("t2 data", d1, 32'hDEADBEEF);
        check("t2 pulse", 32'(p1), 1);
        check("t2 no retrigger", 32'(a2), 0);
        check("t2 pulse one cycle", 32'(user_read_pulse), 0);
        rd("t2 status", 32'h01000404, 32'h00000001);

        // Overrun and clear
        capture(32'h1);
        capture(32'h2);
        rd("t3 status", 32'h01000404, 32'hC0000003);
        wr(32'h01000408, 4'b0001, 32'h3);
        rd("t3 status clr", 32'h01000404, 32'h80000000);
        rd("t3 ctrl", 32'h01000408, 32'h1);

        // Capture during DATA-read ack cycle
        xfer(1, 32'h01000400, 1, 4'hF, 0, 0, 0, 0, 1, 32'h3, a1, d1, p1, a2, d2);
        check("t4 old word", d1, 32'h2);
        rd("t4 status", 32'h01000404, 32'h80000001);

        // Capture disabled; out-of-window select
        wr(32'h01000408, 4'hF, 32'h0);
        repeat (3) capture(32'hBAD0BAD0);
        rd("t5 status", 32'h01000404, 32'h80000001);
        rd("t5 data", 32'h01000400, 32'h3);
        opb_select = 1; opb_abus = 32'h01000500; opb_rnw = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("t5 miss ack", 32'(sl_xferack), 0);
            check("t5 miss dbus", sl_dbus, 0);
        end
        opb_select = 0;

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            int off; bit rnw, uv0, uv1, clr, capwr;
            logic [0:3] be; logic [31:0] wd, ud0, ud1, exp;
            off = $urandom_range(0, 3);
            rnw = ($urandom_range(0, 2) != 0);
            be  = 4'($urandom);
            wd  = {30'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
            uv0 = $urandom_range(0, 1); uv1 = $urandom_range(0, 1);
            ud0 = $urandom; ud1 = $urandom;
            exp   = model_reg(off);
            capwr = !rnw && be[3] && off == 2;
            clr   = capwr && wd[1];
            model_cycle(uv0, ud0, 0, clr, capwr, wd[0]);
            model_cycle(uv1, ud1, rnw && off == 0, 0, 0, 0);
            xfer(1, 32'h01000400 + 32'(off * 4), rnw, be, wd, 0, uv0, ud0, uv1, ud1,
                 a1, d1, p1, a2, d2);
            check($sformatf("rnd%0d ack", n), 32'(a1), 1);
            check($sformatf("rnd%0d data off%0d", n, off), d1, rnw ? exp : 32'h0);
            check($sformatf("rnd%0d pulse", n), 32'(p1), 32'(rnw && off == 0));
            check($sformatf("rnd%0d idle", n), {31'b0, a2} | d2, 0);
        end

        // Count wrap, then reset during an ack cycle
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            user_valid = 1; user_data_in = 32'(i);
            @(posedge clk); @(negedge clk);
        end
        user_valid = 0;
        rd("t6 status wrap", 32'h01000404, 32'hC0000000);
        opb_select = 1; opb_abus = 32'h01000400; opb_rnw = 1;
        @(posedge clk); #1;
        check("t6 ack before rst", 32'(sl_xferack), 1);
        check("t6 data before rst", sl_dbus, 32'h0000FFFF);
        rst = 1; #1;
        check("t6 ack async drop", 32'(sl_xferack), 0);
        check("t6 dbus async drop", sl_dbus, 0);
        check("t6 pulse async drop", 32'(user_read_pulse), 0);
        @(negedge clk);
        opb_select = 0; rst = 0;
        rd("t6 status after rst", 32'h01000404, 32'h0);
        rd("t6 ctrl after rst", 32'h01000408, 32'h1);
        rd("t6 data after rst", 32'h01000400, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
